mul_unit: RTL
=============

# mul_unit

Issue/retire wrapper around the 4-register pipelined 32x32 unsigned multiplier core (`mul`). It accepts multiply requests over a valid/ready handshake and supplies operand magnitudes to the core. It tracks each request's op and tag alongside the core's data path, applies sign correction, and selects the low or high word. Results are buffered in an in-order response FIFO with backpressure, so the non-stallable core never loses a product.

## Interface
- `TAG_W`, default 5: width of the request/response tag.
- `FIFO_DEPTH`, default 8: response FIFO entries and maximum outstanding requests. Must be a power of two, ≥2. Full throughput requires ≥6.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request can be accepted.
- `req_op` in 2: operation select.
  - 00 MUL: low 32 bits, signed×signed.
  - 01 MULH: high 32 bits, signed×signed.
  - 10 MULHSU: high 32 bits, signed a × unsigned b.
  - 11 MULHU: high 32 bits, unsigned×unsigned.
- `req_a` in 32: operand a.
- `req_b` in 32: operand b.
- `req_tag` in TAG_W: opaque tag, returned with the result.
- `rsp_valid` out 1: result at FIFO head.
- `rsp_ready` in 1: consumer takes result.
- `rsp_data` out 32: result word.
- `rsp_tag` out TAG_W: tag of the result.
- `busy` out 1: outstanding count ≠ 0.

## Operation
- **Accept:** a request is accepted on a rising edge with `req_valid && req_ready`.
- **Outstanding counter** `cnt` (0..FIFO_DEPTH):
  - +1 on accept.
  - −1 on response handshake (`rsp_valid && rsp_ready`).
  - Unchanged when both occur in the same cycle.
- `req_ready = (cnt < FIFO_DEPTH)`, driven combinationally from the `cnt` register only; no dependency on `req_valid`.
- **Operand stage (on accept):**
  - Register |a| and |b| as 32-bit unsigned values. Negation is two's complement; 0x80000000 yields magnitude 0x80000000.
  - a is treated as signed for ops 00/01/10. b is treated as signed for ops 00/01.
  - Register `neg = sign_a XOR sign_b`, where the sign of an unsigned operand is 0.
  - Register op and tag.
  - The registered magnitudes drive the core's `s`/`t` inputs.
- **Sideband shift register:** valid, op, neg and tag move through 5 positions in lockstep with the core, so that position 5 aligns with the core's `d` output.
- **Retire:** when position 5 is valid:
  - Compute `p = neg ? -d : d` (64-bit two's complement).
  - Select `p[31:0]` for op 00, otherwise `p[63:32]`.
  - Write the selected word and tag into the FIFO on the next edge.
- **Response FIFO:**
  - Credit accounting guarantees the FIFO never overflows, so no retire-side stall exists.
  - Write and read in the same cycle are legal at any occupancy, including empty→bypass-free (the written entry becomes visible next cycle) and full.
- **Output defaults:** `rsp_data`/`rsp_tag` are 0 whenever `rsp_valid` = 0.
- **Reset (asynchronous, any time, including mid-flight):**
  - Clears `cnt`, all sideband valids, the FIFO pointers and the operand registers.
  - Core data registers have no reset. Their contents are ignored because the sideband valids are clear.
  - No stale response may ever appear after reset release.
- **Reset values:** `req_ready` = 1, `rsp_valid` = 0, `rsp_data` = 0, `rsp_tag` = 0, `busy` = 0.

## Timing
- **Latency:** accept at edge E0 → FIFO write at E5 → `rsp_valid` = 1 in the cycle after E5 (5 cycles), when the FIFO is empty.
- **Throughput:** one request per cycle sustained, given `rsp_ready` = 1 and FIFO_DEPTH ≥ 6.
- **Backpressure:** with `rsp_ready` held 0, exactly FIFO_DEPTH requests are accepted, then `req_ready` = 0. After the first response handshake at edge Ek, `req_ready` = 1 in the cycle after Ek.
- **Ordering:** strictly in order. Tags are returned in acceptance order.
- `rsp_valid`/`rsp_data`/`rsp_tag` are stable while `rsp_valid && !rsp_ready`.
- The core's `clk` is this block's `clk`. No multicycle paths.

## Test plan
- **Signed low word:** MUL 7×6 → `rsp_data` 0x0000002A, 5 cycles after accept, tag echoed. MUL −3×5 (0xFFFFFFFD, 0x00000005) → 0xFFFFFFF1.
- **Extreme operands:**
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MUL on the same operands → 0x00000000.
  - MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000.
- **Mixed/unsigned high word:** MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MULHU on the same operands → 0xFFFFFFFE. MULHU 0×0xFFFFFFFF → 0.
- **Streaming:** 20 back-to-back random requests with tags 0..19 and `rsp_ready` = 1 → 20 responses on consecutive cycles, first response 5 cycles after the first accept, tags 0..19 in order, data matching the reference model.
- **Backpressure:** `rsp_ready` = 0 with `req_valid` held → exactly 8 accepts, then `req_ready` = 0 and `busy` = 1. Raise `rsp_ready` → 8 in-order responses, with `req_ready` = 1 the cycle after the first handshake. No loss or duplication under random `rsp_ready` toggling over 1000 requests.
- **Reset mid-flight:** 3 requests in the pipeline and 2 in the FIFO; pulse `rst_n` low asynchronously (mid-cycle) → `rsp_valid` = 0, `req_ready` = 1 and `busy` = 0 immediately. No response during the 10 cycles after release. A new MUL 2×3 then returns 6 with correct latency.

Source files
------------

// File: rtl/mul_unit.sv
// mul_unit: valid/ready issue and in-order retire around a 4-stage unsigned 32x32 multiplier.
// Signed ops use operand magnitudes going into the core and a conditional negate coming out.

module mul (
   input  logic        clk,
   input  logic [31:0] s,
   input  logic [31:0] t,
   output logic [63:0] d
);
   logic [31:0] s_q, t_q;
   logic [31:0] pp_ll_q, pp_lh_q, pp_hl_q, pp_hh_q;
   logic [31:0] pp_ll_d, pp_lh_d, pp_hl_d, pp_hh_d;
   logic [63:0] base_q, base_d;
   logic [32:0] mid_q, mid_d;
   logic [63:0] d_q, d_d;

   // 16-bit partial products, then the outer/cross terms, then the final shifted add.
   always_comb begin
      pp_ll_d = 32'(s_q[15:0])  * 32'(t_q[15:0]);
      pp_lh_d = 32'(s_q[15:0])  * 32'(t_q[31:16]);
      pp_hl_d = 32'(s_q[31:16]) * 32'(t_q[15:0]);
      pp_hh_d = 32'(s_q[31:16]) * 32'(t_q[31:16]);
      base_d  = {pp_hh_q, pp_ll_q};
      mid_d   = {1'b0, pp_lh_q} + {1'b0, pp_hl_q};
      d_d     = base_q + {15'd0, mid_q, 16'd0};
   end

   // NOTE: pure datapath registers carry no reset; whatever they hold after reset is
   // ignored because the wrapper's valid bits are cleared, and omitting it saves routing.
   always_ff @(posedge clk) begin
      s_q     <= s;
      t_q     <= t;
      pp_ll_q <= pp_ll_d;
      pp_lh_q <= pp_lh_d;
      pp_hl_q <= pp_hl_d;
      pp_hh_q <= pp_hh_d;
      base_q  <= base_d;
      mid_q   <= mid_d;
      d_q     <= d_d;
   end

   assign d = d_q;
endmodule

module mul_unit #(
   parameter int TAG_W      = 5,
   parameter int FIFO_DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             busy
);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int SB_LEN = 5;

   typedef enum logic [1:0] {
      OP_MUL    = 2'b00,
      OP_MULH   = 2'b01,
      OP_MULHSU = 2'b10,
      OP_MULHU  = 2'b11
   } op_e;

   typedef struct packed {
      logic             valid;
      op_e              op;
      logic             neg;
      logic [TAG_W-1:0] tag;
   } sb_t;

   typedef struct packed {
      logic [31:0]      data;
      logic [TAG_W-1:0] tag;
   } rsp_t;

   logic             accept, rsp_fire, retire, fifo_empty;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      mag_a_q, mag_a_d, mag_b_q, mag_b_d;
   sb_t              sb_q [SB_LEN];
   sb_t              sb_d [SB_LEN];
   op_e              op_in;
   logic             sign_a, sign_b;
   logic [63:0]      core_d;
   logic [63:0]      prod_signed;
   rsp_t             fifo_wr, fifo_head;
   rsp_t             fifo_q [FIFO_DEPTH];
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

   assign req_ready  = (cnt_q < CNT_W'(FIFO_DEPTH));
   assign accept     = req_valid && req_ready;
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign rsp_valid  = !fifo_empty;
   assign rsp_fire   = rsp_valid && rsp_ready;
   assign busy       = (cnt_q != '0);
   assign retire     = sb_q[SB_LEN-1].valid;

   assign op_in  = op_e'(req_op);
   assign sign_a = (op_in != OP_MULHU) && req_a[31];
   assign sign_b = ((op_in == OP_MUL) || (op_in == OP_MULH)) && req_b[31];

   // NOTE: every signal written here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      mag_a_d = mag_a_q;
      mag_b_d = mag_b_q;
      sb_d[0] = sb_q[0];
      sb_d[0].valid = accept;
      if (accept) begin
         mag_a_d     = sign_a ? (32'd0 - req_a) : req_a;
         mag_b_d     = sign_b ? (32'd0 - req_b) : req_b;
         sb_d[0].op  = op_in;
         sb_d[0].neg = sign_a ^ sign_b;
         sb_d[0].tag = req_tag;
      end
      for (int i = 1; i < SB_LEN; i++) begin
         sb_d[i] = sb_q[i-1];
      end
   end

   mul u_core (
      .clk (clk),
      .s   (mag_a_q),
      .t   (mag_b_q),
      .d   (core_d)
   );

   always_comb begin
      prod_signed  = sb_q[SB_LEN-1].neg ? (64'd0 - core_d) : core_d;
      fifo_wr.tag  = sb_q[SB_LEN-1].tag;
      fifo_wr.data = (sb_q[SB_LEN-1].op == OP_MUL) ? prod_signed[31:0] : prod_signed[63:32];
   end

   always_comb begin
      cnt_d    = cnt_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (accept && !rsp_fire) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!accept && rsp_fire) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      if (retire) begin
         wr_ptr_d = wr_ptr_q + CNT_W'(1);
      end
      if (rsp_fire) begin
         rd_ptr_d = rd_ptr_q + CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         mag_a_q  <= '0;
         mag_b_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < SB_LEN; i++) begin
            sb_q[i] <= '0;
         end
      end else begin
         cnt_q    <= cnt_d;
         mag_a_q  <= mag_a_d;
         mag_b_q  <= mag_b_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         for (int i = 0; i < SB_LEN; i++) begin
            sb_q[i] <= sb_d[i];
         end
      end
   end

   // Credits bound outstanding work to FIFO_DEPTH, so a retire always finds a free slot.
   always_ff @(posedge clk) begin
      if (retire) begin
         fifo_q[wr_ptr_q[PTR_W-1:0]] <= fifo_wr;
      end
   end

   assign fifo_head = fifo_q[rd_ptr_q[PTR_W-1:0]];
   assign rsp_data  = rsp_valid ? fifo_head.data : '0;
   assign rsp_tag   = rsp_valid ? fifo_head.tag  : '0;
endmodule
